palette_expander: RTL and testbench

Parametrised indexed-colour expansion bridge between the display/DMA reader and the framebuffer memory. It accepts Avalon-MM slave reads, remaps each address across stripe gaps, and issues byte reads on an Avalon-MM master with up to MAX_PENDING reads outstanding. Each returned byte is expanded through a 2^BPP-entry RGB565 palette into 8/BPP pixels. The palette is host-writable, with optional shadow buffering committed at frame start.

---
 rtl/palette_expander.sv | 217 +++++++++++++++++++++
 tb/tb_palette_expander.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_expander.sv
// Indexed-colour expansion bridge: slave reads are stripe-remapped, issued as byte reads and expanded via an RGB565 palette.
// Latency: master request 1 cycle after accept; expanded response 1 cycle after avm_master_readdatavalid.
// Backpressure: waitrequest while the master request is stalled or MAX_PENDING reads are outstanding.
//
// Ports:
//   clk, reset                  single clock, asynchronous active-high reset
//   avs_slave_*                 read-only slave; readdata carries 8/BPP RGB565 pixels, MSB pixel first
//   avm_master_*                byte-read master toward framebuffer memory
//   avs_palette_*               host palette write port and registered readback
//   frame_start, commit_pending shadow-bank commit control
// Optional feature macro: PALETTE_SHADOW_EN (shadow palette bank committed on frame_start).
module palette_expander #(
    parameter int          BPP         = 4,
    parameter int          MAX_PENDING = 4,
    parameter logic [15:0] STRIPE_LEN  = 16'h1FE0,
    parameter logic [15:0] STRIPE_GAP  = 16'h0020,
    parameter int          NUM_STRIPES = 8,
    localparam int         SDW         = 128 / BPP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            avs_slave_read,
    input  logic [23:0]     avs_slave_address,
    output logic            avs_slave_waitrequest,
    output logic [SDW-1:0]  avs_slave_readdata,
    output logic            avs_slave_readdatavalid,
    output logic            avm_master_read,
    output logic [23:0]     avm_master_address,
    input  logic [7:0]      avm_master_readdata,
    input  logic            avm_master_readdatavalid,
    input  logic            avm_master_waitrequest,
    input  logic [BPP-1:0]  avs_palette_address,
    input  logic [15:0]     avs_palette_writedata,
    input  logic            avs_palette_write,
    output logic [15:0]     avs_palette_readdata,
    input  logic            frame_start,
    output logic            commit_pending
);

    localparam int         NENT     = 1 << BPP;
    localparam int         NPIX     = 8 / BPP;
    localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

    // Reset palette: eight primary colours repeated across the table.
    function automatic logic [15:0] default_colour(input int idx);
        logic [2:0] sel;
        sel = idx[2:0];
        case (sel)
            3'd0:    return 16'h0000;
            3'd1:    return 16'hFFFF;
            3'd2:    return 16'hF800;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'h001F;
            3'd5:    return 16'h07FF;
            3'd6:    return 16'hF81F;
            default: return 16'hFFE0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            avm_read_q,  avm_read_d;
    logic [23:0]     avm_addr_q,  avm_addr_d;
    logic [3:0]      pending_q,   pending_d;
    logic            rsp_vld_q,   rsp_vld_d;
    logic [SDW-1:0]  rsp_dat_q,   rsp_dat_d;
    logic [15:0]     pal_rd_q,    pal_rd_d;
    logic            commit_q,    commit_d;
    logic [15:0]     active_q [NENT];
    logic [15:0]     active_d [NENT];

    logic            accept;
    logic            rsp_take;
    logic [15:0]     stripe_k;
    logic [15:0]     remap_lo;
    logic [SDW-1:0]  expand_dat;
    logic [BPP-1:0]  fld;

    // ------------------------------------------------------------------
    // Slave handshake
    // ------------------------------------------------------------------
    assign avs_slave_waitrequest = (avm_read_q && avm_master_waitrequest) ||
                                   (pending_q == PEND_MAX);
    assign accept   = avs_slave_read && !avs_slave_waitrequest;
    // Returns with nothing outstanding are stale (e.g. issued before a reset).
    assign rsp_take = avm_master_readdatavalid && (pending_q != 4'd0);

    // ------------------------------------------------------------------
    // Stripe remap: each crossed stripe boundary adds one gap. The
    // boundary products are 32-bit so boundaries past 64K never match.
    // ------------------------------------------------------------------
    always_comb begin
        stripe_k = 16'd0;
        for (int i = 1; i < NUM_STRIPES; i++) begin
            if ({16'd0, avs_slave_address[15:0]} >= (i * 32'(STRIPE_LEN)))
                stripe_k = stripe_k + 16'd1;
        end
        // 16-bit sum: wraps within the low field, never carries into [23:16].
        remap_lo = avs_slave_address[15:0] + stripe_k * STRIPE_GAP;
    end

    // ------------------------------------------------------------------
    // Master request and outstanding count
    // ------------------------------------------------------------------
    always_comb begin
        avm_read_d = avm_read_q;
        avm_addr_d = avm_addr_q;
        pending_d  = pending_q;
        // An accept is only possible when the previous request is not
        // stalled, so it never overwrites a held request.
        if (accept) begin
            avm_read_d = 1'b1;
            avm_addr_d = {avs_slave_address[23:16], remap_lo};
        end else if (!(avm_read_q && avm_master_waitrequest)) begin
            avm_read_d = 1'b0;
        end
        if (accept && !rsp_take)
            pending_d = pending_q + 4'd1;
        else if (!accept && rsp_take)
            pending_d = pending_q - 4'd1;
    end

    // ------------------------------------------------------------------
    // Expansion through the active bank, MSB field to MSB pixel
    // ------------------------------------------------------------------
    always_comb begin
        expand_dat = '0;
        fld        = '0;
        for (int k = 0; k < NPIX; k++) begin
            fld = avm_master_readdata[7 - k*BPP -: BPP];
            expand_dat[SDW - 1 - 16*k -: 16] = active_q[fld];
        end
        rsp_vld_d = rsp_take;
        rsp_dat_d = rsp_take ? expand_dat : rsp_dat_q;
    end

    // ------------------------------------------------------------------
    // Palette banks
    // ------------------------------------------------------------------
`ifdef PALETTE_SHADOW_EN
    logic [15:0] shadow_q [NENT];
    logic [15:0] shadow_d [NENT];
    logic        do_commit;

    // Host writes land in the shadow bank; the copy uses shadow_d so a
    // write in the commit cycle is part of the committed palette.
    always_comb begin
        shadow_d = shadow_q;
        if (avs_palette_write)
            shadow_d[avs_palette_address] = avs_palette_writedata;
        do_commit = frame_start && commit_q;
        active_d  = active_q;
        if (do_commit)
            active_d = shadow_d;
        if (do_commit)
            commit_d = 1'b0;
        else
            commit_d = commit_q || avs_palette_write;
        pal_rd_d = shadow_q[avs_palette_address];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NENT; i++)
                shadow_q[i] <= default_colour(i);
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;

    always_comb begin
        active_d = active_q;
        if (avs_palette_write)
            active_d[avs_palette_address] = avs_palette_writedata;
        commit_d = 1'b0;
        pal_rd_d = active_q[avs_palette_address];
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_read_q <= 1'b0;
            avm_addr_q <= 24'd0;
            pending_q  <= 4'd0;
            rsp_vld_q  <= 1'b0;
            rsp_dat_q  <= '0;
            pal_rd_q   <= 16'd0;
            commit_q   <= 1'b0;
            for (int i = 0; i < NENT; i++)
                active_q[i] <= default_colour(i);
        end else begin
            avm_read_q <= avm_read_d;
            avm_addr_q <= avm_addr_d;
            pending_q  <= pending_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
            pal_rd_q   <= pal_rd_d;
            commit_q   <= commit_d;
            active_q   <= active_d;
        end
    end

    assign avm_master_read         = avm_read_q;
    assign avm_master_address      = avm_addr_q;
    assign avs_slave_readdatavalid = rsp_vld_q;
    assign avs_slave_readdata      = rsp_dat_q;
    assign avs_palette_readdata    = pal_rd_q;
    assign commit_pending          = commit_q;

endmodule

// File: tb/tb_palette_expander.sv
// Directed bench for palette_expander: BPP=4 main instance plus a BPP=2 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
// Shadow-bank expectations follow PALETTE_SHADOW_EN when it is defined for the build.
module tb_palette_expander;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    // BPP=4 instance
    logic        s_read;
    logic [23:0] s_addr;
    logic        s_wait;
    logic [31:0] s_rdata;
    logic        s_rdv;
    logic        m_read;
    logic [23:0] m_addr;
    logic [7:0]  m_rdata;
    logic        m_rdv;
    logic        m_wait;
    logic [3:0]  p_addr;
    logic [15:0] p_wdata;
    logic        p_write;
    logic [15:0] p_rdata;
    logic        frame_start;
    logic        commit_pending;

    // BPP=2 instance
    logic        b_read;
    logic [23:0] b_addr;
    logic        b_wait;
    logic [63:0] b_rdata;
    logic        b_rdv;
    logic        b_mread;
    logic [23:0] b_maddr;
    logic [7:0]  b_mrdata;
    logic        b_mrdv;
    logic [1:0]  b_paddr;
    logic [15:0] b_prdata;
    logic        b_commit;

    palette_expander #(.BPP(4)) u_dut (
        .clk                      (clk),
        .reset                    (reset),
        .avs_slave_read           (s_read),
        .avs_slave_address        (s_addr),
        .avs_slave_waitrequest    (s_wait),
        .avs_slave_readdata       (s_rdata),
        .avs_slave_readdatavalid  (s_rdv),
        .avm_master_read          (m_read),
        .avm_master_address       (m_addr),
        .avm_master_readdata      (m_rdata),
        .avm_master_readdatavalid (m_rdv),
        .avm_master_waitrequest   (m_wait),
        .avs_palette_address      (p_addr),
        .avs_palette_writedata    (p_wdata),
        .avs_palette_write        (p_write),
        .avs_palette_readdata     (p_rdata),
        .frame_start              (frame_start),
        .commit_pending           (commit_pending)
    );

    palette_expander #(.BPP(2)) u_dut2 (
        .clk                      (clk),
        .reset                    (reset),
        .avs_slave_read           (b_read),
        .avs_slave_address        (b_addr),
        .avs_slave_waitrequest    (b_wait),
        .avs_slave_readdata       (b_rdata),
        .avs_slave_readdatavalid  (b_rdv),
        .avm_master_read          (b_mread),
        .avm_master_address       (b_maddr),
        .avm_master_readdata      (b_mrdata),
        .avm_master_readdatavalid (b_mrdv),
        .avm_master_waitrequest   (1'b0),
        .avs_palette_address      (b_paddr),
        .avs_palette_writedata    (16'h0000),
        .avs_palette_write        (1'b0),
        .avs_palette_readdata     (b_prdata),
        .frame_start              (1'b0),
        .commit_pending           (b_commit)
    );

`ifdef PALETTE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a read until it is accepted; returns 1 unit after the accept edge.
    task automatic do_read(input string tag, input logic [23:0] a);
        bit ok;
        ok     = 1'b0;
        s_read = 1'b1;
        s_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = !s_wait;
            tick();
        end
        s_read = 1'b0;
        if (!ok)
            check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    // One-cycle memory return.
    task automatic mem_ret(input logic [7:0] d);
        m_rdv   = 1'b1;
        m_rdata = d;
        tick();
        m_rdv   = 1'b0;
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [15:0] d);
        p_addr  = a;
        p_wdata = d;
        p_write = 1'b1;
        tick();
        p_write = 1'b0;
    endtask

    typedef struct {
        logic [23:0] slave_a;
        logic [23:0] master_a;
    } remap_vec_t;

    remap_vec_t remap_tbl [4];

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] pix;
    } drain_vec_t;

    drain_vec_t drain_tbl [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        remap_tbl[0] = '{24'h001FE0, 24'h002000};
        remap_tbl[1] = '{24'h00DF20, 24'h00E000};
        remap_tbl[2] = '{24'h051FDF, 24'h051FDF};
        remap_tbl[3] = '{24'h3F3FC0, 24'h3F4000};

        drain_tbl[0] = '{8'h01, 32'h0000_FFFF};
        drain_tbl[1] = '{8'h23, 32'hF800_07E0};
        drain_tbl[2] = '{8'h45, 32'h001F_07FF};
        drain_tbl[3] = '{8'h67, 32'hF81F_FFE0};

        reset = 1'b1;
        s_read = 1'b0; s_addr = 24'd0;
        m_rdata = 8'd0; m_rdv = 1'b0; m_wait = 1'b0;
        p_addr = 4'd0; p_wdata = 16'd0; p_write = 1'b0;
        frame_start = 1'b0;
        b_read = 1'b0; b_addr = 24'd0; b_mrdata = 8'd0; b_mrdv = 1'b0; b_paddr = 2'd0;

        // Reset state
        #12;
        check("rst_wait",   64'(s_wait),         64'd0);
        check("rst_rdv",    64'(s_rdv),          64'd0);
        check("rst_rdata",  64'(s_rdata),        64'd0);
        check("rst_mread",  64'(m_read),         64'd0);
        check("rst_maddr",  64'(m_addr),         64'd0);
        check("rst_palrd",  64'(p_rdata),        64'd0);
        check("rst_commit", 64'(commit_pending), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Default palette readback
        p_addr = 4'd5;
        tick();
        check("pal_default5", 64'(p_rdata), 64'h07FF);
        p_addr = 4'd9;
        tick();
        check("pal_default9", 64'(p_rdata), 64'hFFFF);

        // Basic read and expansion
        do_read("rd0", 24'h000010);
        check("rd0_mread", 64'(m_read), 64'd1);
        check("rd0_maddr", 64'(m_addr), 64'h000010);
        mem_ret(8'h12);
        check("rd0_rdv",   64'(s_rdv),   64'd1);
        check("rd0_rdata", 64'(s_rdata), 64'hFFFF_F800);
        check("rd0_mdrop", 64'(m_read),  64'd0);
        tick();
        check("rd0_rdv_low", 64'(s_rdv),   64'd0);
        check("rd0_hold",    64'(s_rdata), 64'hFFFF_F800);

        // Stripe remap
        foreach (remap_tbl[i]) begin
            do_read("remap", remap_tbl[i].slave_a);
            check("remap_maddr", 64'(m_addr), 64'(remap_tbl[i].master_a));
            mem_ret(8'h00);
        end

        // Master waitrequest holds the request and stalls the slave
        m_wait = 1'b1;
        do_read("hold", 24'h001FE1);
        check("hold_maddr0", 64'(m_addr), 64'h002001);
        @(negedge clk);
        check("hold_swait", 64'(s_wait), 64'd1);
        tick();
        check("hold_mread", 64'(m_read), 64'd1);
        check("hold_maddr", 64'(m_addr), 64'h002001);
        m_wait = 1'b0;
        tick();
        check("hold_release", 64'(m_read), 64'd0);
        mem_ret(8'h00);

        // Backpressure: four back-to-back accepts, then full
        s_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_addr = 24'h000100 + 24'(i);
            @(negedge clk);
            check("bp_accept", 64'(s_wait), 64'd0);
            tick();
            check("bp_maddr", 64'(m_addr), 64'h000100 + 64'(i));
        end
        @(negedge clk);
        check("bp_full", 64'(s_wait), 64'd1);
        m_rdv   = 1'b1;
        m_rdata = 8'h12;
        tick();
        m_rdv  = 1'b0;
        s_addr = 24'h000200;
        check("bp_rsp_rdv", 64'(s_rdv), 64'd1);
        @(negedge clk);
        check("bp_room", 64'(s_wait), 64'd0);
        tick();
        s_read = 1'b0;
        check("bp_reaccept", 64'(m_addr), 64'h000200);
        @(negedge clk);
        check("bp_full2", 64'(s_wait), 64'd1);
        tick();
        foreach (drain_tbl[i]) begin
            mem_ret(drain_tbl[i].idx);
            check("drain_rdata", 64'(s_rdata), 64'(drain_tbl[i].pix));
        end
        check("drain_wait", 64'(s_wait), 64'd0);
        mem_ret(8'h89);
        check("stale_rdv",  64'(s_rdv),   64'd0);
        check("stale_hold", 64'(s_rdata), 64'hF81F_FFE0);

        // Palette write and expansion
        pal_write(4'd3, 16'h1234);
        check("pw_commit", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        do_read("pw", 24'h000040);
        mem_ret(8'h33);
        check("pw_expand", 64'(s_rdata), SHADOW ? 64'h07E0_07E0 : 64'h1234_1234);
        check("pw_readback", 64'(p_rdata), 64'h1234);
        pal_write(4'd3, 16'h5555);
        check("pw_same_cycle_old", 64'(p_rdata), 64'h1234);
        tick();
        check("pw_new", 64'(p_rdata), 64'h5555);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_commit_clr", 64'(commit_pending), 64'd0);
        do_read("fs", 24'h000041);
        mem_ret(8'h33);
        check("fs_expand", 64'(s_rdata), 64'h5555_5555);

        // Shadow commit with a write in the commit cycle
        pal_write(4'd0, 16'hABCD);
        check("sh_pending", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        do_read("sh0", 24'h000050);
        mem_ret(8'h00);
        check("sh_pre", 64'(s_rdata), SHADOW ? 64'h0000_0000 : 64'hABCD_ABCD);
        frame_start = 1'b1;
        p_addr  = 4'd1;
        p_wdata = 16'h1111;
        p_write = 1'b1;
        tick();
        frame_start = 1'b0;
        p_write     = 1'b0;
        check("sh_clear", 64'(commit_pending), 64'd0);
        do_read("sh1", 24'h000051);
        mem_ret(8'h01);
        check("sh_post", 64'(s_rdata), 64'hABCD_1111);

        // BPP=2 expansion
        b_read = 1'b1;
        b_addr = 24'h000007;
        @(negedge clk);
        check("b2_wait", 64'(b_wait), 64'd0);
        tick();
        b_read = 1'b0;
        check("b2_maddr", 64'(b_maddr), 64'h000007);
        b_mrdv   = 1'b1;
        b_mrdata = 8'b00_01_10_11;
        tick();
        b_mrdv = 1'b0;
        check("b2_rdv",   64'(b_rdv),   64'd1);
        check("b2_rdata", b_rdata,      64'h0000_FFFF_F800_07E0);

        // Reset mid-burst: outstanding read forgotten, palette restored
        do_read("mid", 24'h000300);
        p_addr = 4'd3;
        reset  = 1'b1;
        #2;
        check("mid_rst_mread", 64'(m_read),  64'd0);
        check("mid_rst_rdata", 64'(s_rdata), 64'd0);
        reset = 1'b0;
        tick();
        check("mid_pal_restored", 64'(p_rdata), 64'h07E0);
        mem_ret(8'hFF);
        check("mid_stale_rdv", 64'(s_rdv), 64'd0);
        do_read("post", 24'h000010);
        mem_ret(8'h12);
        check("post_rdata", 64'(s_rdata), 64'hFFFF_F800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
